dro_pulse_capture: RTL and testbench
====================================

// Module: dro_pulse_capture
// PURPOSE
//   Downstream consumer of the DRO cell output. Samples the transition-coded SFQ line (each toggle = one
//   pulse) on a clock and detects every toggle as a one-cycle event. Stores a free-running cycle timestamp
//   per event in a small FIFO, drained by a valid/ready reader.
//   Sits between the DRO cell under test and the bench/VCD checker that verifies output pulse timing.
// PARAMETERS
//   TS_W        16  timestamp width; free-running counter wraps modulo 2^TS_W
//   DEPTH       8   FIFO entries; power of two, >=2
//   SYNC_STAGES 2   synchronizer flops on pulse_in; >=2
//   CNT_W       16  width of statistics counters (used only with DRO_CAPTURE_STATS_EN)
// PORTS
//   clk          in   1      capture clock, rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   pulse_in     in   1      transition-coded SFQ line from the DRO out
//   enable       in   1      1 = record events; 0 = detect but discard
//   clr          in   1      synchronous clear of ovf_sticky (and stats counters)
//   ts_valid     out  1      FIFO head holds a timestamp
//   ts_ready     in   1      reader accepts head this cycle
//   ts_data      out  TS_W   timestamp at FIFO head
//   ovf_sticky   out  1      an event was dropped because the FIFO was full
//   pulse_count  out  CNT_W  [DRO_CAPTURE_STATS_EN] events detected while enable=1
//   drop_count   out  CNT_W  [DRO_CAPTURE_STATS_EN] events dropped on full FIFO
// BEHAVIOUR
//   Reset: sync chain, prev, armed, ts counter, FIFO pointers and all counters are 0. Outputs are
//     ts_valid=0, ts_data=0, ovf_sticky=0, stats=0. Reset mid-operation discards all FIFO contents.
//   Timestamp: ts_cnt increments every clk from 0, independent of enable, wrapping 2^TS_W-1 -> 0.
//   Detection: sync = last stage of SYNC_STAGES flops, prev <= sync, evt = armed & (sync ^ prev).
//     armed rises SYNC_STAGES+1 cycles after reset release. Before that, prev tracks sync with no
//     event, so a line already high at release produces no spurious pulse.
//   Latency: a toggle first sampled at edge k asserts evt in the cycle after edge k+SYNC_STAGES-1.
//     The value pushed is ts_cnt in that evt cycle. ts_valid rises one cycle later if the FIFO was empty.
//   Resolution limit: two toggles inside one clk period cancel and are not detected. This is a
//     documented limitation, not an error.
//   enable=0: evt is still computed (prev keeps tracking) but nothing is pushed or counted.
//   FIFO: show-ahead. ts_data = mem[rd_ptr], ts_valid = !empty. Pop when ts_valid & ts_ready.
//     ts_data is held stable while ts_valid & !ts_ready. ts_data is 0 when empty.
//   Push when evt & enable & (!full | pop). Full with a same-cycle pop accepts the push.
//   Full with no pop drops the event and sets ovf_sticky. ovf_sticky holds until clr=1.
//     If clr and a drop occur in the same cycle, set wins.
//   Pointers are log2(DEPTH)+1 bits. empty = ptrs equal. full = MSBs differ and the rest are equal.
// CONFIGURATION
//   `DRO_CAPTURE_STATS_EN defined: pulse_count increments on every evt & enable. drop_count increments
//     on every dropped event. Both saturate at 2^CNT_W-1, are cleared by clr, and clr wins over increment.
//   Not defined: pulse_count/drop_count ports are absent. All other behaviour is identical.
// STRUCTURE
//   Package dro_capture_pkg: default TS_W/DEPTH/CNT_W constants, typedef ts_t, and function clog2 for
//     pointer width.
//   Sub-module dro_ts_fifo: a DEPTH x TS_W show-ahead FIFO with push/pop/full/empty, async reset.
//     The top module holds the synchronizer, edge detect, arm logic, timestamp counter, sticky and stats.
//   Module is simulated with timescale 1ps/100fs, matching the cell models.
// TESTING
//   1. Reset release with pulse_in=1 held -> no event, ts_valid stays 0 for 20 cycles.
//   2. Three toggles 10 cycles apart, enable=1, ts_ready=0 -> 3 entries. Differences between
//      successive ts_data values = 10. Drain with ts_ready=1 -> values in order, then ts_valid=0.
//   3. DEPTH+2 = 10 toggles, ts_ready=0 -> 8 entries, ovf_sticky=1, drop_count=2 (STATS).
//      Then clr -> ovf_sticky=0.
//   4. FIFO full, toggle in the same cycle as pop -> push accepted, count stays 8, ovf_sticky stays 0.
//   5. enable=0 during 4 toggles, then enable=1 and 1 toggle -> exactly 1 entry, pulse_count=1.
//   6. TS_W=4: toggle at ts_cnt=15 and next at ts_cnt=0 -> entries 15 then 0. Assert rst_n low with
//      entries queued -> ts_valid=0 immediately and stays 0 after release.

Source files
------------

// File: rtl/dro_capture_pkg.sv
// Shared constants, timestamp type and pointer-width helper for the DRO pulse capture block.
`timescale 1ps/100fs
package dro_capture_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef logic [TS_W_DEF-1:0] ts_t;

  // Smallest n with 2**n >= value; evaluated at elaboration for pointer widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dro_ts_fifo.sv
// Show-ahead DEPTH x WIDTH timestamp FIFO; head is presented combinationally, zero when empty.
`timescale 1ps/100fs
module dro_ts_fifo
  import dro_capture_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = TS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here unconditionally) so no latch is inferred.
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_i};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; resetting the pointers already invalidates every entry.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/dro_pulse_capture.sv
// Timestamps each toggle of the transition-coded SFQ line from the DRO cell into a FIFO.
// Define DRO_CAPTURE_STATS_EN to add the pulse_count/drop_count statistics ports.
`timescale 1ps/100fs
module dro_pulse_capture
  import dro_capture_pkg::*;
#(
  parameter int TS_W        = TS_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = 2
`ifdef DRO_CAPTURE_STATS_EN
  ,
  parameter int CNT_W       = CNT_W_DEF
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pulse_in,
  input  logic            enable,
  input  logic            clr,
  output logic            ts_valid,
  input  logic            ts_ready,
  output logic [TS_W-1:0] ts_data,
  output logic            ovf_sticky
`ifdef DRO_CAPTURE_STATS_EN
  ,
  output logic [CNT_W-1:0] pulse_count,
  output logic [CNT_W-1:0] drop_count
`endif
);

  localparam int ARM_W = clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   armed_q, armed_d;
  logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic [TS_W-1:0]        ts_cnt_q;
  logic                   ovf_q, ovf_d;

  logic sync, evt, rec, pop, push, drop, full, empty;

  // Arming waits until prev has caught up with the synchronized line after reset.
  always_comb begin
    arm_cnt_d = arm_cnt_q;
    armed_d   = armed_q;
    if (!armed_q) begin
      arm_cnt_d = arm_cnt_q + ARM_W'(1);
      armed_d   = (arm_cnt_q == ARM_W'(SYNC_STAGES));
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign evt  = armed_q & (sync ^ prev_q);
  assign rec  = evt & enable;
  assign pop  = ts_valid & ts_ready;
  assign push = rec & (!full | pop);
  assign drop = rec & full & !pop;

  always_comb begin
    ovf_d = ovf_q;
    if (drop)     ovf_d = 1'b1;
    else if (clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      armed_q   <= 1'b0;
      arm_cnt_q <= '0;
      ts_cnt_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      prev_q    <= sync;
      armed_q   <= armed_d;
      arm_cnt_q <= arm_cnt_d;
      ts_cnt_q  <= ts_cnt_q + TS_W'(1);
      ovf_q     <= ovf_d;
    end
  end

  dro_ts_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TS_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (ts_cnt_q),
    .rdata_o (ts_data),
    .full_o  (full),
    .empty_o (empty)
  );

  assign ts_valid   = !empty;
  assign ovf_sticky = ovf_q;

`ifdef DRO_CAPTURE_STATS_EN
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating counters; clr takes priority over a same-cycle increment.
  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (clr) begin
      pulse_cnt_d = '0;
      drop_cnt_d  = '0;
    end else begin
      if (rec  && (pulse_cnt_q != '1)) pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
      if (drop && (drop_cnt_q  != '1)) drop_cnt_d  = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      pulse_cnt_q <= pulse_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign pulse_count = pulse_cnt_q;
  assign drop_count  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dro_pulse_capture.sv
// Scoreboard bench for dro_pulse_capture: a 16-bit timestamp instance plus a 4-bit one for wrap and reset.
`timescale 1ps/100fs
module tb_dro_pulse_capture;

  localparam int TS_W  = 16;
  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int TS4_W = 4;
  localparam int HALF  = 5;

  logic clk = 1'b0;
  always #HALF clk = ~clk;

  // Main instance
  logic            rst_n, pulse_in, enable, clr, ts_ready;
  logic            ts_valid, ovf_sticky;
  logic [TS_W-1:0] ts_data;
  // Small-timestamp instance
  logic             r4_n, p4, rdy4;
  logic             v4, ovf4;
  logic [TS4_W-1:0] d4;
`ifdef DRO_CAPTURE_STATS_EN
  logic [15:0] pulse_count, drop_count, pc4, dc4;
`endif

  dro_pulse_capture #(.TS_W(TS_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pulse_in   (pulse_in),
    .enable     (enable),
    .clr        (clr),
    .ts_valid   (ts_valid),
    .ts_ready   (ts_ready),
    .ts_data    (ts_data),
    .ovf_sticky (ovf_sticky)
`ifdef DRO_CAPTURE_STATS_EN
    ,
    .pulse_count (pulse_count),
    .drop_count  (drop_count)
`endif
  );

  dro_pulse_capture #(.TS_W(TS4_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut4 (
    .clk        (clk),
    .rst_n      (r4_n),
    .pulse_in   (p4),
    .enable     (1'b1),
    .clr        (1'b0),
    .ts_valid   (v4),
    .ts_ready   (rdy4),
    .ts_data    (d4),
    .ovf_sticky (ovf4)
`ifdef DRO_CAPTURE_STATS_EN
    ,
    .pulse_count (pc4),
    .drop_count  (dc4)
`endif
  );

  int checks = 0;
  int errors = 0;
  int exp_pulses = 0;
  int exp_drops  = 0;

  logic [TS_W-1:0]  exp_q [$];
  logic [TS4_W-1:0] exp4_q [$];

  // Cycle-count references for the timestamp each instance should be showing.
  logic [TS_W-1:0]  m_ts;
  logic [TS4_W-1:0] m4;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_ts <= '0; else m_ts <= m_ts + 16'd1;
  always @(posedge clk or negedge r4_n)
    if (!r4_n) m4 <= '0; else m4 <= m4 + 4'd1;

  // A toggle driven at a falling edge is stamped with the count SYNC cycles later.
  task automatic toggle_rec();
    @(negedge clk);
    pulse_in = ~pulse_in;
    if (enable) begin
      exp_pulses++;
      if (exp_q.size() < DEPTH) exp_q.push_back(m_ts + 16'(SYNC));
      else exp_drops++;
    end
  endtask

  task automatic drain(input int n_exp, input int spacing, input string name);
    int got;
    int guard;
    logic [TS_W-1:0] last_v;
    logic [TS_W-1:0] e;
    got = 0;
    guard = 0;
    last_v = '0;
    @(negedge clk);
    ts_ready = 1'b1;
    while (guard < 60) begin
      if (ts_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s_extra: got entry %0d, required none", name, ts_data);
        end else begin
          e = exp_q.pop_front();
          if (ts_data !== e) begin
            errors++;
            $display("FAIL %s_data: got %0d, required %0d", name, ts_data, e);
          end
        end
        if (spacing > 0 && got > 0) begin
          checks++;
          if (ts_data - last_v !== 16'(spacing)) begin
            errors++;
            $display("FAIL %s_spacing: got %0d, required %0d", name, ts_data - last_v, spacing);
          end
        end
        last_v = ts_data;
        got++;
      end else if (exp_q.size() == 0) begin
        break;
      end
      @(negedge clk);
      guard++;
    end
    ts_ready = 1'b0;
    checks++;
    if (guard >= 60 || got != n_exp) begin
      errors++;
      $display("FAIL %s_count: got %0d entries, required %0d", name, got, n_exp);
    end
    checks++;
    if (ts_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_empty: ts_valid=%b, required 0", name, ts_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; r4_n = 1'b0;
    pulse_in = 1'b1; p4 = 1'b0;
    enable = 1'b1; clr = 1'b0; ts_ready = 1'b0; rdy4 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ts_valid !== 1'b0 || ts_data !== '0 || ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%0d ovf=%b, required 0 0 0", ts_valid, ts_data, ovf_sticky);
    end
`ifdef DRO_CAPTURE_STATS_EN
    checks++;
    if (pulse_count !== '0 || drop_count !== '0) begin
      errors++;
      $display("FAIL reset_stats: pulses=%0d drops=%0d, required 0 0", pulse_count, drop_count);
    end
`endif
    rst_n = 1'b1; r4_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (ts_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_high_line cycle %0d: ts_valid=%b, required 0", i, ts_valid);
      end
    end
  endtask

  task automatic test_spacing();
    toggle_rec();
    repeat (9) @(negedge clk);
    toggle_rec();
    repeat (9) @(negedge clk);
    toggle_rec();
    repeat (SYNC + 2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ts_valid !== 1'b1 || ts_data !== exp_q[0]) begin
        errors++;
        $display("FAIL spacing_head_hold: valid=%b data=%0d, required 1 %0d", ts_valid, ts_data, exp_q[0]);
      end
      @(negedge clk);
    end
    drain(3, 10, "spacing");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 2; i++) begin
      toggle_rec();
      @(negedge clk);
    end
    repeat (SYNC + 2) @(negedge clk);
    checks++;
    if (ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b, required 1", ovf_sticky);
    end
    checks++;
    if (ts_valid !== 1'b1 || ts_data !== exp_q[0]) begin
      errors++;
      $display("FAIL ovf_head: valid=%b data=%0d, required 1 %0d", ts_valid, ts_data, exp_q[0]);
    end
`ifdef DRO_CAPTURE_STATS_EN
    checks++;
    if (drop_count !== 16'(exp_drops) || pulse_count !== 16'(exp_pulses)) begin
      errors++;
      $display("FAIL ovf_stats: pulses=%0d drops=%0d, required %0d %0d", pulse_count, drop_count, exp_pulses, exp_drops);
    end
`endif
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    exp_pulses = 0; exp_drops = 0;
    checks++;
    if (ovf_sticky !== 1'b0 || ts_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clr: ovf=%b valid=%b, required 0 1", ovf_sticky, ts_valid);
    end
`ifdef DRO_CAPTURE_STATS_EN
    checks++;
    if (drop_count !== '0 || pulse_count !== '0) begin
      errors++;
      $display("FAIL ovf_clr_stats: pulses=%0d drops=%0d, required 0 0", pulse_count, drop_count);
    end
`endif
  endtask

  // FIFO is full on entry; the new event lands in the same cycle as a pop.
  task automatic test_full_pop();
    logic [TS_W-1:0] e_new;
    logic [TS_W-1:0] e_old;
    @(negedge clk);
    pulse_in = ~pulse_in;
    e_new = m_ts + 16'(SYNC);
    exp_pulses++;
    repeat (SYNC) @(negedge clk);
    ts_ready = 1'b1;
    e_old = exp_q.pop_front();
    exp_q.push_back(e_new);
    checks++;
    if (ts_data !== e_old) begin
      errors++;
      $display("FAIL full_pop_head: got %0d, required %0d", ts_data, e_old);
    end
    @(negedge clk);
    ts_ready = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_ovf: got %b, required 0", ovf_sticky);
    end
`ifdef DRO_CAPTURE_STATS_EN
    checks++;
    if (drop_count !== '0 || pulse_count !== 16'(exp_pulses)) begin
      errors++;
      $display("FAIL full_pop_stats: pulses=%0d drops=%0d, required %0d 0", pulse_count, drop_count, exp_pulses);
    end
`endif
    drain(DEPTH, 0, "full_pop");
  endtask

  task automatic test_enable();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    exp_pulses = 0;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      toggle_rec();
      @(negedge clk);
    end
    repeat (SYNC + 2) @(negedge clk);
    checks++;
    if (ts_valid !== 1'b0) begin
      errors++;
      $display("FAIL enable_off: ts_valid=%b, required 0", ts_valid);
    end
    enable = 1'b1;
    toggle_rec();
    repeat (SYNC + 2) @(negedge clk);
`ifdef DRO_CAPTURE_STATS_EN
    checks++;
    if (pulse_count !== 16'd1) begin
      errors++;
      $display("FAIL enable_pulses: got %0d, required 1", pulse_count);
    end
`endif
    drain(1, 0, "enable");
  endtask

  task automatic test_wrap_reset();
    int guard;
    guard = 0;
    @(negedge clk);
    while (m4 != 4'(15 - SYNC) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 40) begin
      errors++;
      $display("FAIL wrap_align: timestamp %0d not reached, required %0d", m4, 15 - SYNC);
    end
    p4 = ~p4; exp4_q.push_back(4'd15);
    @(negedge clk);
    p4 = ~p4; exp4_q.push_back(4'd0);
    repeat (SYNC + 2) @(negedge clk);
    checks++;
    if (v4 !== 1'b1 || d4 !== exp4_q[0]) begin
      errors++;
      $display("FAIL wrap_first: valid=%b data=%0d, required 1 %0d", v4, d4, exp4_q[0]);
    end
    void'(exp4_q.pop_front());
    rdy4 = 1'b1;
    @(negedge clk);
    rdy4 = 1'b0;
    checks++;
    if (v4 !== 1'b1 || d4 !== exp4_q[0]) begin
      errors++;
      $display("FAIL wrap_second: valid=%b data=%0d, required 1 %0d", v4, d4, exp4_q[0]);
    end
    r4_n = 1'b0;
    exp4_q.delete();
    #1;
    checks++;
    if (v4 !== 1'b0 || d4 !== '0) begin
      errors++;
      $display("FAIL midrun_reset: valid=%b data=%0d, required 0 0", v4, d4);
    end
    @(negedge clk);
    r4_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (v4 !== 1'b0) begin
        errors++;
        $display("FAIL post_reset cycle %0d: valid=%b, required 0", i, v4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_spacing();
    test_overflow();
    test_full_pop();
    test_enable();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
